// File: rtl/arb_pkg.sv
// Shared types for the clocked round-robin / fixed-priority arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ACKED, RELEASE} arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/arb_rr_pick.sv
// Combinational masked priority encoder: first set request at or after ptr,
// wrapping; ptr is forced to 0 for fixed priority.
module arb_rr_pick #(
  parameter int N_REQ = 32,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

  logic [2*N_REQ-2:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   eff_ptr;
  logic [IDX_W-1:0]   rot_idx;
  logic [IDX_W:0]     sum;

  assign eff_ptr = mode ? ptr : '0;
  // Concatenated copy lets a plain index implement the rotation.
  assign dbl     = {req[N_REQ-2:0], req};
  assign any     = |req;

  always_comb begin
    rot     = '0;
    rot_idx = '0;
    sum     = '0;
    idx     = '0;
    onehot  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = dbl[i + int'(eff_ptr)];
    end
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) rot_idx = i[IDX_W-1:0];
    end
    sum = {1'b0, rot_idx} + {1'b0, eff_ptr};
    if (sum >= N_W) sum = sum - N_W;
    idx = sum[IDX_W-1:0];
    if (any) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/arbiter_rr_sync.sv
// Clocked N-way four-phase arbiter forwarding one granted request downstream,
// with optional input synchronisers and round-robin or fixed priority.
module arbiter_rr_sync
  import arb_pkg::*;
#(
  parameter int N_REQ       = 32,
  parameter int MODE        = 1,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  logic [N_REQ-1:0] rq_s;
  logic             ak_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rq_s = req_in;
      assign ak_s = ack_out;
    end else begin : g_sync
      logic [N_REQ:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= {ack_out, req_in};
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign rq_s = sync_q[SYNC_STAGES-1][N_REQ-1:0];
      assign ak_s = sync_q[SYNC_STAGES-1][N_REQ];
    end
  endgenerate

  arb_state_t       state_q;
  logic [N_REQ-1:0] sel_q, ack_q;
  logic [IDX_W-1:0] idx_q, rr_ptr_q, rr_ptr_d;
  logic             req_out_q;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  arb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (rq_s),
    .ptr    (rr_ptr_q),
    .mode   (MODE == ARB_RR),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign rr_ptr_d = (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;

  // Handshake: each side is four-phase (req up, ack up, req down, ack down);
  // sel and idx are latched in IDLE and held until RELEASE completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ack_q     <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      req_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            sel_q     <= pick_onehot;
            idx_q     <= pick_idx;
            req_out_q <= 1'b1;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (ak_s) begin
            ack_q   <= sel_q;
            state_q <= ACKED;
          end
        end
        ACKED: begin
          if ((rq_s & sel_q) == '0) begin
            req_out_q <= 1'b0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ak_s) begin
            ack_q   <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            if (MODE == ARB_RR) rr_ptr_q <= rr_ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_in    = ack_q;
  assign req_out   = req_out_q;
  assign sel       = sel_q;
  assign sel_idx   = idx_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_arbiter_rr_sync.sv
// Directed bench: three 4-channel arbiters (RR/sync2, fixed/sync2, RR/no-sync)
// driven through four-phase handshakes with hand-computed expectations.
module tb_arbiter_rr_sync;
  localparam int W_REQ_HI = 0;
  localparam int W_REQ_LO = 1;
  localparam int W_ACK_HI = 2;
  localparam int W_ACK_LO = 3;

  logic       clk;
  logic       rst;
  logic [3:0] req_in    [3];
  logic       ack_out   [3];
  logic [3:0] ack_in    [3];
  logic       req_out   [3];
  logic [3:0] sel       [3];
  logic [1:0] sel_idx   [3];
  logic       busy      [3];
  logic [1:0] state_dbg [3];

  int errors = 0;
  int checks = 0;

  arbiter_rr_sync #(.N_REQ(4), .MODE(1), .SYNC_STAGES(2)) dut_rr (
    .clk(clk), .rst(rst), .req_in(req_in[0]), .ack_in(ack_in[0]),
    .req_out(req_out[0]), .ack_out(ack_out[0]), .sel(sel[0]),
    .sel_idx(sel_idx[0]), .busy(busy[0]), .state_dbg(state_dbg[0])
  );
  arbiter_rr_sync #(.N_REQ(4), .MODE(0), .SYNC_STAGES(2)) dut_fp (
    .clk(clk), .rst(rst), .req_in(req_in[1]), .ack_in(ack_in[1]),
    .req_out(req_out[1]), .ack_out(ack_out[1]), .sel(sel[1]),
    .sel_idx(sel_idx[1]), .busy(busy[1]), .state_dbg(state_dbg[1])
  );
  arbiter_rr_sync #(.N_REQ(4), .MODE(1), .SYNC_STAGES(0)) dut_s0 (
    .clk(clk), .rst(rst), .req_in(req_in[2]), .ack_in(ack_in[2]),
    .req_out(req_out[2]), .ack_out(ack_out[2]), .sel(sel[2]),
    .sel_idx(sel_idx[2]), .busy(busy[2]), .state_dbg(state_dbg[2])
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_until(input int d, input int what, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      case (what)
        W_REQ_HI: hit = req_out[d];
        W_REQ_LO: hit = !req_out[d];
        W_ACK_HI: hit = (ack_in[d] != 4'b0);
        default:  hit = (ack_in[d] == 4'b0);
      endcase
    end
    check({tag, " wait"}, {31'b0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
  endtask

  // One full four-phase transfer on channel exp_sel; requests are rewritten
  // after the ack and again when req_out falls.
  task automatic serve(input int d, input logic [3:0] exp_sel, input logic [1:0] exp_idx,
                       input logic [3:0] after_ack, input logic [3:0] after_rel,
                       input string tag);
    wait_until(d, W_REQ_HI, tag);
    check({tag, " sel"}, sel[d], exp_sel);
    check({tag, " idx"}, sel_idx[d], exp_idx);
    check({tag, " busy"}, busy[d], 1);
    ack_out[d] = 1'b1;
    wait_until(d, W_ACK_HI, tag);
    check({tag, " ack_in"}, ack_in[d], exp_sel);
    req_in[d] = after_ack;
    wait_until(d, W_REQ_LO, tag);
    check({tag, " sel held"}, sel[d], exp_sel);
    req_in[d] = after_rel;
    ack_out[d] = 1'b0;
    wait_until(d, W_ACK_LO, tag);
    check({tag, " sel clr"}, sel[d], 0);
    check({tag, " idx clr"}, sel_idx[d], 0);
  endtask

  // Invariants on every DUT, every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        check("ack_in onehot0", {31'b0, $onehot0(ack_in[d])}, 1);
        check("ack_in in sel", ack_in[d] & ~sel[d], 0);
        check("sel onehot0", {31'b0, $onehot0(sel[d])}, 1);
        check("req_out needs sel", {31'b0, req_out[d] && (sel[d] == 4'b0)}, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_in[d]  = 4'b0;
      ack_out[d] = 1'b0;
    end
    tick(1);
    do_reset();
    for (int d = 0; d < 3; d++) begin
      check("rst req_out", req_out[d], 0);
      check("rst sel", sel[d], 0);
      check("rst busy", busy[d], 0);
      check("rst state", state_dbg[d], 0);
    end

    // Single request: req_out appears 3 cycles later with idx 2.
    req_in[0] = 4'b0100;
    tick(2);
    check("t1 lat2 req_out", req_out[0], 0);
    tick(1);
    check("t1 lat3 req_out", req_out[0], 1);
    serve(0, 4'b0100, 2'd2, 4'b0000, 4'b0000, "t1");
    check("t1 busy done", busy[0], 0);

    // Round robin with all four held.
    do_reset();
    req_in[0] = 4'b1111;
    serve(0, 4'b0001, 2'd0, 4'b1110, 4'b1111, "t2 g0");
    serve(0, 4'b0010, 2'd1, 4'b1101, 4'b1111, "t2 g1");
    serve(0, 4'b0100, 2'd2, 4'b1011, 4'b1111, "t2 g2");
    serve(0, 4'b1000, 2'd3, 4'b0111, 4'b1111, "t2 g3");
    serve(0, 4'b0001, 2'd0, 4'b0000, 4'b0000, "t2 g0b");
    tick(4);
    check("t2 idle", busy[0], 0);

    // Late arrival of channel 3 while channel 0 is acknowledged.
    req_in[0] = 4'b0001;
    wait_until(0, W_REQ_HI, "t4 grant");
    check("t4 sel0", sel[0], 4'b0001);
    ack_out[0] = 1'b1;
    wait_until(0, W_ACK_HI, "t4 ack");
    check("t4 state acked", state_dbg[0], 2);
    req_in[0] = 4'b1001;
    tick(4);
    check("t4 sel stable", sel[0], 4'b0001);
    req_in[0] = 4'b1000;
    wait_until(0, W_REQ_LO, "t4 rel");
    check("t4 sel in rel", sel[0], 4'b0001);
    ack_out[0] = 1'b0;
    wait_until(0, W_ACK_LO, "t4 done");
    serve(0, 4'b1000, 2'd3, 4'b0000, 4'b0000, "t4 g3");

    // Fixed priority: channel 1 re-requests as soon as req_out falls, so it
    // is back in the synchronised view before the arbiter returns to IDLE.
    req_in[1] = 4'b1010;
    serve(1, 4'b0010, 2'd1, 4'b1000, 4'b1010, "t3 a");
    serve(1, 4'b0010, 2'd1, 4'b1000, 4'b1010, "t3 b");
    serve(1, 4'b0010, 2'd1, 4'b1000, 4'b1000, "t3 c");
    serve(1, 4'b1000, 2'd3, 4'b0000, 4'b0000, "t3 d");

    // Reset mid-handshake, with rr_ptr moved to 2 beforehand.
    req_in[0] = 4'b0010;
    serve(0, 4'b0010, 2'd1, 4'b0000, 4'b0000, "t5 pre");
    req_in[0] = 4'b0100;
    wait_until(0, W_REQ_HI, "t5 grant");
    ack_out[0] = 1'b1;
    wait_until(0, W_ACK_HI, "t5 ack");
    check("t5 state acked", state_dbg[0], 2);
    rst = 1'b0;
    #1;
    check("t5 rst ack_in", ack_in[0], 0);
    check("t5 rst req_out", req_out[0], 0);
    check("t5 rst sel", sel[0], 0);
    check("t5 rst idx", sel_idx[0], 0);
    check("t5 rst busy", busy[0], 0);
    req_in[0]  = 4'b0000;
    ack_out[0] = 1'b0;
    tick(2);
    rst = 1'b1;
    req_in[0] = 4'b1001;
    tick(2);
    check("t5 lat2 req_out", req_out[0], 0);
    tick(1);
    check("t5 lat3 req_out", req_out[0], 1);
    serve(0, 4'b0001, 2'd0, 4'b0000, 4'b0000, "t5 fresh");

    // No synchroniser: one-cycle latency, and a withdrawn request is never acked.
    req_in[2] = 4'b0001;
    tick(1);
    check("t6 lat1 req_out", req_out[2], 1);
    check("t6 sel", sel[2], 4'b0001);
    req_in[2] = 4'b0011;
    ack_out[2] = 1'b1;
    wait_until(2, W_ACK_HI, "t6 ack");
    check("t6 ack_in", ack_in[2], 4'b0001);
    req_in[2] = 4'b0010;
    wait_until(2, W_REQ_LO, "t6 rel");
    req_in[2] = 4'b0000;
    ack_out[2] = 1'b0;
    wait_until(2, W_ACK_LO, "t6 done");
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t6 no req_out", req_out[2], 0);
      check("t6 no ack_in", ack_in[2], 0);
      check("t6 idle", busy[2], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
